l1i_miss_handler: RTL and testbench
===================================

# l1i_miss_handler

Refill engine on the far side of the L1 instruction cache's miss/update interface. Accepts miss reports from the L1I cache, queues them, fetches the two consecutive 64-byte lines for each miss from the memory side, and returns them through a single-cycle cache-update pulse. It sits between the fetch-stage L1I cache and the L2/memory port.

## Interface
Parameters:
- fetchingAddressWidth, 64, address width
- cacheLineWith, 512, line width in bits
- offsetWidth, 6, byte-offset bits within a line
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, instruction major ID width
- missQueueDepth, 4, pending-miss entries (power of two)

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high
- cacheMiss_i  in  1  miss report valid, one cycle per miss
- missedAddress_i  in  fetchingAddressWidth  missed fetch address
- missedInstMajorId_i  in  instructionCounterWidth  ID of the missing fetch
- missedPid_i / missedTid_i  in  PidSize / TidSize  owner of the miss
- missQueueFull_o  out  1  queue holds missQueueDepth entries
- memReqValid_o  out  1  line read request valid
- memReqReady_i  in  1  memory accepts request
- memReqAddress_o  out  fetchingAddressWidth  line-aligned request address
- memRespValid_i  in  1  one line returned
- memRespLine_i  in  cacheLineWith  returned line data
- cacheUpdate_o  out  1  update pulse to L1I
- cacheUpdateAddress_o  out  fetchingAddressWidth  original missed address
- cacheUpdatePid_o / cacheUpdateTid_o  out  PidSize / TidSize  owner
- cacheUpdateInstMajorId_o  out  instructionCounterWidth  ID of the refilled miss
- cacheUpdateLine1_o / cacheUpdateLine2_o  out  cacheLineWith  line at base / base+64

## Operation
- Miss queue: FIFO of {address, majorId, pid, tid}, depth missQueueDepth, wrap-around read/write pointers plus count.
- Push when cacheMiss_i=1, count<missQueueDepth, and not a duplicate. Duplicate = some valid entry, including the head currently being serviced, with the same pid and the same line address (address with low offsetWidth bits cleared). Duplicates and misses arriving while full are dropped silently.
- Full is evaluated on the pre-edge count. A push while full is dropped even in the cycle the head pops.
- Base line = missedAddress & ~((1<<offsetWidth)-1). Second line = base + (1<<offsetWidth), modulo 2^fetchingAddressWidth; wraps to 0 at the top address.
- FSM states:
  - IDLE: go to REQ1 if the queue is non-empty.
  - REQ1: memReqValid_o=1, memReqAddress_o=base. On memReqValid_o & memReqReady_i, go to WAIT1.
  - WAIT1: on memRespValid_i, capture the line into line1 and go to REQ2.
  - REQ2: as REQ1 with the second-line address. On handshake, go to WAIT2.
  - WAIT2: on memRespValid_i, capture line2 and go to UPDATE.
  - UPDATE: cacheUpdate_o=1 for exactly one cycle with head fields and both lines. Pop the head and go to IDLE.
- memRespValid_i is ignored outside WAIT1/WAIT2. The memory returns a response no earlier than the cycle after the request is accepted.
- memReqAddress_o holds stable while memReqValid_o=1 and the request is unaccepted.

## Timing
- All outputs are registered.
- Reset values: every output is 0, FSM in IDLE, queue empty, pointers and count 0.
- Reset mid-operation: the outstanding request is abandoned and queued misses are lost. A late memRespValid_i after reset is ignored, because the FSM is in IDLE.
- Queue behaviour:
  - Miss sampled at edge E appears in the queue after E.
  - missQueueFull_o reflects the count after each edge.
- Minimum latency, with ready held high and each response one cycle after acceptance:
  - Miss sampled at edge 0.
  - REQ1 after edge 1.
  - Request accepted at edge 2.
  - Line 1 sampled at edge 3.
  - Request 2 accepted at edge 4.
  - Line 2 sampled at edge 5.
  - cacheUpdate_o high between edges 5 and 6.
  - Next REQ1 is asserted after edge 7.
- Back-to-back misses are serviced strictly in FIFO order, one at a time.

## Test plan
- Single miss:
  - Stimulus: missedAddress_i=0x04, pid=0, tid=0, majorId=7. Memory returns 0xAAAA… then 0xEEEE….
  - Required response: request addresses 0x00 then 0x40. One cacheUpdate_o pulse with address 0x04, majorId 7, line1=0xAAAA…, line2=0xEEEE…, at the minimum latency.
- Duplicate suppression:
  - Stimulus: misses at 0x04 and 0x3C with the same pid, both inside line 0, while the first is in service.
  - Required response: only one refill occurs. Then a miss at 0x04 with pid=1 is queued and refilled.
- Full queue:
  - Stimulus: 5 distinct-line misses with memReqReady_i held low.
  - Required response: missQueueFull_o=1 after the 4th. The 5th is dropped. Releasing ready yields exactly 4 updates in order.
- Backpressure and stray response:
  - Stimulus: hold memReqReady_i low 3 cycles. Pulse memRespValid_i during REQ1.
  - Required response: the address stays stable, the stray response is ignored, and line1 is taken from the WAIT1 response.
- Address wrap:
  - Stimulus: miss at 0xFFFF_FFFF_FFFF_FFC8.
  - Required response: requests to 0xFFFF_FFFF_FFFF_FFC0 then 0x0.
- Reset in WAIT2:
  - Stimulus: assert reset_i asynchronously between clock edges, then deliver a response after release.
  - Required response: all outputs go to 0 immediately, and no cacheUpdate_o follows.

Source files
------------

// File: rtl/l1i_miss_handler.sv
// l1i_miss_handler: queues L1I misses, fetches two consecutive lines per miss and returns them as one update pulse
module l1i_miss_handler #(
    parameter int fetchingAddressWidth = 64,
    parameter int cacheLineWith = 512,
    parameter int offsetWidth = 6,
    parameter int PidSize = 20,
    parameter int TidSize = 16,
    parameter int instructionCounterWidth = 64,
    parameter int missQueueDepth = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               cacheMiss_i,
    input  logic [fetchingAddressWidth-1:0]    missedAddress_i,
    input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
    input  logic [PidSize-1:0]                 missedPid_i,
    input  logic [TidSize-1:0]                 missedTid_i,
    output logic                               missQueueFull_o,
    output logic                               memReqValid_o,
    input  logic                               memReqReady_i,
    output logic [fetchingAddressWidth-1:0]    memReqAddress_o,
    input  logic                               memRespValid_i,
    input  logic [cacheLineWith-1:0]           memRespLine_i,
    output logic                               cacheUpdate_o,
    output logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_o,
    output logic [PidSize-1:0]                 cacheUpdatePid_o,
    output logic [TidSize-1:0]                 cacheUpdateTid_o,
    output logic [instructionCounterWidth-1:0] cacheUpdateInstMajorId_o,
    output logic [cacheLineWith-1:0]           cacheUpdateLine1_o,
    output logic [cacheLineWith-1:0]           cacheUpdateLine2_o
);
    localparam int ptrW = missQueueDepth > 1 ? $clog2(missQueueDepth) : 1;
    localparam logic [ptrW:0] depthCnt = (ptrW+1)'(missQueueDepth);
    localparam logic [fetchingAddressWidth-1:0] lineMask =
        {{(fetchingAddressWidth-offsetWidth){1'b1}}, {offsetWidth{1'b0}}};
    localparam logic [fetchingAddressWidth-1:0] lineStep =
        {{(fetchingAddressWidth-1){1'b0}}, 1'b1} << offsetWidth;

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, UPDATE} stateT;
    stateT state, stateNext;

    logic [fetchingAddressWidth-1:0]    addrQ [missQueueDepth];
    logic [instructionCounterWidth-1:0] idQ   [missQueueDepth];
    logic [PidSize-1:0]                 pidQ  [missQueueDepth];
    logic [TidSize-1:0]                 tidQ  [missQueueDepth];
    logic [ptrW-1:0] rdPtr, wrPtr;
    logic [ptrW:0] count, countNext;
    logic dup, push, pop;
    logic [fetchingAddressWidth-1:0] headBase;

    // The head stays valid until UPDATE, so a miss to the line being refilled is also suppressed
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < missQueueDepth; i++)
            if ({1'b0, ptrW'(i) - rdPtr} < count && pidQ[i] == missedPid_i &&
                (addrQ[i] & lineMask) == (missedAddress_i & lineMask))
                dup = 1'b1;
    end

    assign push = cacheMiss_i && count != depthCnt && !dup;
    assign pop = state == UPDATE;
    assign countNext = count + (ptrW+1)'(push) - (ptrW+1)'(pop);
    assign headBase = addrQ[rdPtr] & lineMask;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = count != '0 ? REQ1 : IDLE;
            REQ1:    stateNext = memReqReady_i ? WAIT1 : REQ1;
            WAIT1:   stateNext = memRespValid_i ? REQ2 : WAIT1;
            REQ2:    stateNext = memReqReady_i ? WAIT2 : REQ2;
            WAIT2:   stateNext = memRespValid_i ? UPDATE : WAIT2;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock_i)
        if (push) begin
            addrQ[wrPtr] <= missedAddress_i;
            idQ[wrPtr] <= missedInstMajorId_i;
            pidQ[wrPtr] <= missedPid_i;
            tidQ[wrPtr] <= missedTid_i;
        end

    always_ff @(posedge clock_i or posedge reset_i)
        if (reset_i) begin
            state <= IDLE;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            missQueueFull_o <= 1'b0;
            memReqValid_o <= 1'b0;
            memReqAddress_o <= '0;
            cacheUpdate_o <= 1'b0;
            cacheUpdateAddress_o <= '0;
            cacheUpdatePid_o <= '0;
            cacheUpdateTid_o <= '0;
            cacheUpdateInstMajorId_o <= '0;
            cacheUpdateLine1_o <= '0;
            cacheUpdateLine2_o <= '0;
        end else begin
            state <= stateNext;
            wrPtr <= wrPtr + ptrW'(push);
            rdPtr <= rdPtr + ptrW'(pop);
            count <= countNext;
            missQueueFull_o <= countNext == depthCnt;
            memReqValid_o <= stateNext == REQ1 || stateNext == REQ2;
            memReqAddress_o <= stateNext == REQ1 ? headBase :
                               stateNext == REQ2 ? headBase + lineStep : memReqAddress_o;
            cacheUpdate_o <= state == WAIT2 && memRespValid_i;
            if (state == WAIT1 && memRespValid_i)
                cacheUpdateLine1_o <= memRespLine_i;
            if (state == WAIT2 && memRespValid_i) begin
                cacheUpdateLine2_o <= memRespLine_i;
                cacheUpdateAddress_o <= addrQ[rdPtr];
                cacheUpdatePid_o <= pidQ[rdPtr];
                cacheUpdateTid_o <= tidQ[rdPtr];
                cacheUpdateInstMajorId_o <= idQ[rdPtr];
            end
        end
endmodule

// File: tb/tb_l1i_miss_handler.sv
// tb_l1i_miss_handler: directed vectors and multi-cycle corner sequences for the L1I refill engine
module tb_l1i_miss_handler;
    localparam int AW = 64, LW = 512, PW = 20, TW = 16, IW = 64;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    logic cacheMiss_i = 1'b0;
    logic [AW-1:0] missedAddress_i = '0;
    logic [IW-1:0] missedInstMajorId_i = '0;
    logic [PW-1:0] missedPid_i = '0;
    logic [TW-1:0] missedTid_i = '0;
    logic missQueueFull_o, memReqValid_o, cacheUpdate_o;
    logic memReqReady_i = 1'b0;
    logic memRespValid_i = 1'b0;
    logic [LW-1:0] memRespLine_i = '0;
    logic [AW-1:0] memReqAddress_o, cacheUpdateAddress_o;
    logic [PW-1:0] cacheUpdatePid_o;
    logic [TW-1:0] cacheUpdateTid_o;
    logic [IW-1:0] cacheUpdateInstMajorId_o;
    logic [LW-1:0] cacheUpdateLine1_o, cacheUpdateLine2_o;

    int passCount = 0;
    int checkCount = 0;

    l1i_miss_handler dut (
        .clock_i(clock_i), .reset_i(reset_i), .cacheMiss_i(cacheMiss_i),
        .missedAddress_i(missedAddress_i), .missedInstMajorId_i(missedInstMajorId_i),
        .missedPid_i(missedPid_i), .missedTid_i(missedTid_i), .missQueueFull_o(missQueueFull_o),
        .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i), .memReqAddress_o(memReqAddress_o),
        .memRespValid_i(memRespValid_i), .memRespLine_i(memRespLine_i), .cacheUpdate_o(cacheUpdate_o),
        .cacheUpdateAddress_o(cacheUpdateAddress_o), .cacheUpdatePid_o(cacheUpdatePid_o),
        .cacheUpdateTid_o(cacheUpdateTid_o), .cacheUpdateInstMajorId_o(cacheUpdateInstMajorId_o),
        .cacheUpdateLine1_o(cacheUpdateLine1_o), .cacheUpdateLine2_o(cacheUpdateLine2_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] pid;
        logic [TW-1:0] tid;
        logic [IW-1:0] id;
        logic [LW-1:0] l1;
        logic [LW-1:0] l2;
        logic [AW-1:0] req1;
        logic [AW-1:0] req2;
    } vecT;
    vecT vecs[4];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic miss(input logic [AW-1:0] a, input logic [PW-1:0] p, input logic [IW-1:0] id);
        cacheMiss_i = 1'b1;
        missedAddress_i = a;
        missedPid_i = p;
        missedTid_i = '0;
        missedInstMajorId_i = id;
        tick();
        cacheMiss_i = 1'b0;
    endtask

    task automatic waitReq(input string name);
        for (int n = 0; n < 50 && !memReqValid_o; n++) tick();
        chk(name, LW'(memReqValid_o), LW'(1'b1));
    endtask

    // Refill one queued miss with ready held high; lines are derived from the base address
    task automatic serve(input string name, input logic [AW-1:0] a, input logic [PW-1:0] p, input logic [IW-1:0] id);
        logic [AW-1:0] b;
        b = a & ~64'h3F;
        waitReq({name, " req1"});
        chk({name, " addr1"}, LW'(memReqAddress_o), LW'(b));
        tick();
        memRespValid_i = 1'b1;
        memRespLine_i = {8{b}};
        tick();
        memRespValid_i = 1'b0;
        waitReq({name, " req2"});
        chk({name, " addr2"}, LW'(memReqAddress_o), LW'(b + 64'h40));
        tick();
        memRespValid_i = 1'b1;
        memRespLine_i = {8{~b}};
        tick();
        memRespValid_i = 1'b0;
        chk({name, " upd"}, LW'(cacheUpdate_o), LW'(1'b1));
        chk({name, " updAddr"}, LW'(cacheUpdateAddress_o), LW'(a));
        chk({name, " updPid"}, LW'(cacheUpdatePid_o), LW'(p));
        chk({name, " updId"}, LW'(cacheUpdateInstMajorId_o), LW'(id));
        chk({name, " line1"}, cacheUpdateLine1_o, {8{b}});
        chk({name, " line2"}, cacheUpdateLine2_o, {8{~b}});
        tick();
    endtask

    task automatic quiet(input string name);
        logic saw;
        saw = 1'b0;
        for (int n = 0; n < 10; n++) begin
            saw = saw | memReqValid_o | cacheUpdate_o;
            tick();
        end
        chk(name, LW'(saw), LW'(1'b0));
    endtask

    initial begin
        vecs[0] = '{64'h4, 20'h0, 16'h0, 64'd7, {64{8'hAA}}, {64{8'hEE}}, 64'h0, 64'h40};
        vecs[1] = '{64'h1234_5678_9ABC_DEF7, 20'h5, 16'h3, 64'd100, {16{32'h1357_9BDF}},
                    {16{32'h2468_ACE0}}, 64'h1234_5678_9ABC_DEC0, 64'h1234_5678_9ABC_DF00};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFC8, 20'h9, 16'h1, 64'd55, {64{8'h11}}, {64{8'h22}},
                    64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
        vecs[3] = '{64'h7F, 20'hFFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, {64{8'h5A}}, {64{8'hA5}},
                    64'h40, 64'h80};

        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("rst full", LW'(missQueueFull_o), LW'(1'b0));
        chk("rst reqValid", LW'(memReqValid_o), LW'(1'b0));
        chk("rst reqAddr", LW'(memReqAddress_o), '0);
        chk("rst update", LW'(cacheUpdate_o), LW'(1'b0));
        chk("rst line1", cacheUpdateLine1_o, '0);

        // Cycle-exact refills at minimum latency
        memReqReady_i = 1'b1;
        for (int v = 0; v < 4; v++) begin
            cacheMiss_i = 1'b1;
            missedAddress_i = vecs[v].addr;
            missedPid_i = vecs[v].pid;
            missedTid_i = vecs[v].tid;
            missedInstMajorId_i = vecs[v].id;
            tick();
            cacheMiss_i = 1'b0;
            chk($sformatf("v%0d idle", v), LW'(memReqValid_o), LW'(1'b0));
            tick();
            chk($sformatf("v%0d req1", v), LW'(memReqValid_o), LW'(1'b1));
            chk($sformatf("v%0d addr1", v), LW'(memReqAddress_o), LW'(vecs[v].req1));
            tick();
            chk($sformatf("v%0d wait1", v), LW'(memReqValid_o), LW'(1'b0));
            memRespValid_i = 1'b1;
            memRespLine_i = vecs[v].l1;
            tick();
            memRespValid_i = 1'b0;
            chk($sformatf("v%0d req2", v), LW'(memReqValid_o), LW'(1'b1));
            chk($sformatf("v%0d addr2", v), LW'(memReqAddress_o), LW'(vecs[v].req2));
            tick();
            memRespValid_i = 1'b1;
            memRespLine_i = vecs[v].l2;
            tick();
            memRespValid_i = 1'b0;
            chk($sformatf("v%0d upd", v), LW'(cacheUpdate_o), LW'(1'b1));
            chk($sformatf("v%0d updAddr", v), LW'(cacheUpdateAddress_o), LW'(vecs[v].addr));
            chk($sformatf("v%0d updPid", v), LW'(cacheUpdatePid_o), LW'(vecs[v].pid));
            chk($sformatf("v%0d updTid", v), LW'(cacheUpdateTid_o), LW'(vecs[v].tid));
            chk($sformatf("v%0d updId", v), LW'(cacheUpdateInstMajorId_o), LW'(vecs[v].id));
            chk($sformatf("v%0d line1", v), cacheUpdateLine1_o, vecs[v].l1);
            chk($sformatf("v%0d line2", v), cacheUpdateLine2_o, vecs[v].l2);
            tick();
            chk($sformatf("v%0d pulse", v), LW'(cacheUpdate_o), LW'(1'b0));
        end

        // Duplicate suppression, including against the head in service and a non-head entry
        memReqReady_i = 1'b0;
        miss(64'h04, 20'h2, 64'd1);
        miss(64'h3C, 20'h2, 64'd2);
        miss(64'h04, 20'h2, 64'd3);
        miss(64'h04, 20'h1, 64'd4);
        miss(64'h20, 20'h1, 64'd5);
        chk("dup full", LW'(missQueueFull_o), LW'(1'b0));
        memReqReady_i = 1'b1;
        serve("dup a", 64'h04, 20'h2, 64'd1);
        serve("dup b", 64'h04, 20'h1, 64'd4);
        quiet("dup extra");

        // Full queue: fifth distinct miss dropped
        memReqReady_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            miss(64'h100 * k + 64'h8, 20'h3, IW'(10 + k));
            chk($sformatf("full after %0d", k), LW'(missQueueFull_o), LW'(k >= 4));
        end
        memReqReady_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            serve($sformatf("fifo %0d", k), 64'h100 * k + 64'h8, 20'h3, IW'(10 + k));
            chk($sformatf("fifo %0d full", k), LW'(missQueueFull_o), LW'(1'b0));
        end
        quiet("full extra");

        // Backpressure with a stray response during REQ1
        memReqReady_i = 1'b0;
        miss(64'h2004, 20'h4, 64'd21);
        tick();
        chk("bp req", LW'(memReqValid_o), LW'(1'b1));
        chk("bp addr", LW'(memReqAddress_o), LW'(64'h2000));
        memRespValid_i = 1'b1;
        memRespLine_i = {16{32'hDEAD_BEEF}};
        for (int n = 0; n < 3; n++) begin
            tick();
            memRespValid_i = 1'b0;
            chk($sformatf("bp hold %0d", n), LW'(memReqValid_o), LW'(1'b1));
            chk($sformatf("bp stable %0d", n), LW'(memReqAddress_o), LW'(64'h2000));
        end
        memReqReady_i = 1'b1;
        tick();
        chk("bp accepted", LW'(memReqValid_o), LW'(1'b0));
        memRespValid_i = 1'b1;
        memRespLine_i = {16{32'h600D_CAFE}};
        tick();
        memRespValid_i = 1'b0;
        chk("bp addr2", LW'(memReqAddress_o), LW'(64'h2040));
        tick();
        memRespValid_i = 1'b1;
        memRespLine_i = {16{32'h0BAD_F00D}};
        tick();
        memRespValid_i = 1'b0;
        chk("bp upd", LW'(cacheUpdate_o), LW'(1'b1));
        chk("bp line1", cacheUpdateLine1_o, {16{32'h600D_CAFE}});
        chk("bp line2", cacheUpdateLine2_o, {16{32'h0BAD_F00D}});
        tick();

        // Asynchronous reset while waiting for the second line
        miss(64'h3008, 20'h6, 64'd31);
        tick();
        tick();
        memRespValid_i = 1'b1;
        memRespLine_i = {64{8'h77}};
        tick();
        memRespValid_i = 1'b0;
        chk("wait2 pre", LW'(memReqAddress_o), LW'(64'h3040));
        tick();
        #3;
        reset_i = 1'b1;
        #1;
        chk("arst reqValid", LW'(memReqValid_o), LW'(1'b0));
        chk("arst reqAddr", LW'(memReqAddress_o), '0);
        chk("arst line1", cacheUpdateLine1_o, '0);
        chk("arst full", LW'(missQueueFull_o), LW'(1'b0));
        #2;
        reset_i = 1'b0;
        memRespValid_i = 1'b1;
        memRespLine_i = {64{8'h99}};
        tick();
        memRespValid_i = 1'b0;
        quiet("arst late resp");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
